// File: rtl/bcd_sched_pkg.sv
// Shared types and command indices for the BCD command scheduler.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    INIT_REQ,
    IDLE,
    WAIT_ACK,
    WAIT_REL
  } sched_state_e;

  localparam int unsigned CMD_INIT    = 0;
  localparam int unsigned CMD_LOAD_A  = 1;
  localparam int unsigned CMD_LOAD_B  = 2;
  localparam int unsigned CMD_ADD_LS  = 3;
  localparam int unsigned CMD_DISP_MS = 4;

endpackage

// File: rtl/bcd_rr_arbiter.sv
// Combinational N_REQ-way round-robin pick: first set request at or after ptr.
module bcd_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int unsigned j;
    logic [PW-1:0] jj;
    j         = 0;
    jj        = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j  = (32'(ptr) + i) % N_REQ;
      jj = PW'(j);
      if (!grant_vld && req[jj]) begin
        grant_idx = jj;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_cmd_scheduler.sv
// Round-robin command scheduler issuing one REQ/ACK handshake at a time to the BCD datapath.
// Optional handshake watchdog enabled by defining BCD_SCHED_TIMEOUT_EN.
module bcd_cmd_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TW             = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ_PULSE,
  output logic [N_REQ:0]   CMD_REQ,
  input  logic [N_REQ:0]   CMD_ACK,
  output logic [N_REQ-1:0] PENDING,
  output logic             BUSY,
  output logic             TIMEOUT_ERR
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GW = $clog2(N_REQ + 1);

  sched_state_e     state, state_nx;
  logic [N_REQ:0]   cmd_req, cmd_req_nx;
  logic [N_REQ-1:0] pending, pending_nx, pending_clr;
  logic             busy, busy_nx;
  logic [PW-1:0]    rr_ptr, rr_ptr_nx;
  logic [GW-1:0]    g, g_nx;
  logic             hs_done;
  logic [PW-1:0]    grant_idx;
  logic             grant_vld;
  logic             wd_fire;

  bcd_rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

`ifdef BCD_SCHED_TIMEOUT_EN
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_cnt;
  logic          to_err;

  assign wd_fire     = ((state == WAIT_ACK) || (state == WAIT_REL)) && (wd_cnt == WD_LAST);
  assign TIMEOUT_ERR = to_err;

  // Held at zero outside the handshake states, so it is clear on every entry to WAIT_ACK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if ((state == INIT_REQ) || (state == IDLE)) wd_cnt <= '0;
      else                                        wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) to_err <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    cmd_req_nx  = cmd_req;
    busy_nx     = busy;
    g_nx        = g;
    rr_ptr_nx   = rr_ptr;
    pending_clr = '0;
    hs_done     = 1'b0;
    unique case (state)
      INIT_REQ: begin
        cmd_req_nx = (N_REQ + 1)'(1) << CMD_INIT;
        busy_nx    = 1'b1;
        g_nx       = '0;
        state_nx   = WAIT_ACK;
      end
      IDLE: begin
        if (grant_vld) begin
          cmd_req_nx  = (N_REQ + 1)'(2) << grant_idx;
          pending_clr = N_REQ'(1) << grant_idx;
          g_nx        = GW'(grant_idx) + GW'(1);
          busy_nx     = 1'b1;
          state_nx    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (CMD_ACK[g]) begin
          cmd_req_nx = '0;
          state_nx   = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!CMD_ACK[g]) hs_done = 1'b1;
      end
      default: state_nx = INIT_REQ;
    endcase
    if (wd_fire) begin
      cmd_req_nx = '0;
      hs_done    = 1'b1;
    end
    // g-1 was the served requester, so g mod N_REQ is the one after it.
    if (hs_done) begin
      state_nx = IDLE;
      busy_nx  = 1'b0;
      if (g != '0) rr_ptr_nx = (g == GW'(N_REQ)) ? '0 : PW'(g);
    end
  end

  // A pulse landing on the grant edge of the same bit re-sets it.
  assign pending_nx = (pending & ~pending_clr) | REQ_PULSE;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= INIT_REQ;
      cmd_req <= '0;
      pending <= '0;
      busy    <= 1'b0;
      rr_ptr  <= '0;
      g       <= '0;
    end else begin
      state   <= state_nx;
      cmd_req <= cmd_req_nx;
      pending <= pending_nx;
      busy    <= busy_nx;
      rr_ptr  <= rr_ptr_nx;
      g       <= g_nx;
    end
  end

  assign CMD_REQ = cmd_req;
  assign PENDING = pending;
  assign BUSY    = busy;

endmodule
